sc_fir_engine: RTL
==================

SC_FIR_ENGINE -- requirements
Module: sc_fir_engine

Interface
REQ-001 Parameter N, default 12, sample and coefficient width; stream length is 2^N cycles.
REQ-002 Parameter TAPS, default 19, number of FIR taps (filter order TAPS-1).
REQ-003 Derived parameter AW = $clog2(TAPS) sets the coefficient address width, and OW = N+1+AW sets the output width.
REQ-004 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_data, input, N bits: unsigned unipolar sample, value x/2^N.
REQ-007 Port in_valid, input, 1 bit: in_data is offered.
REQ-008 Port in_ready, output, 1 bit: the block can accept a sample; high only in IDLE.
REQ-009 Port coef_we, input, 1 bit: coefficient write strobe.
REQ-010 Port coef_addr, input, AW bits: tap index written.
REQ-011 Port coef_data, input, N bits: unsigned unipolar coefficient.
REQ-012 Port out, output, OW bits: binary filter result, the sum of the per-tap ones-counts.
REQ-013 Port out_valid, output, 1 bit: one-cycle pulse when out is updated.

Function
REQ-014 Storage SHALL be a delay line x[0..TAPS-1] (x[0] newest) and coefficient registers c[0..TAPS-1], each N bits.
REQ-015 FSM states SHALL be IDLE and RUN; in_ready = (state==IDLE).
REQ-016 Accept: at an edge with in_valid && in_ready, x[k] <= x[k-1] for k>=1, x[0] <= in_data, stream counter cnt <= 0, accumulator acc <= 0, state <= RUN.
REQ-017 In RUN, each cycle SHALL compute for every tap b[k] = (cnt < x[k]) AND (bitrev_N(cnt) < c[k]), a counter-SNG times a van-der-Corput SNG.
REQ-018 In RUN, each edge SHALL do acc <= acc + popcount(b) and cnt <= cnt+1.
REQ-019 On the RUN edge where cnt == 2^N-1: out <= acc + popcount(b), out_valid <= 1, state <= IDLE, cnt wraps to 0.
REQ-020 Latency: out_valid SHALL be high in the cycle following the 2^N-th edge after the accepting edge, for exactly one cycle.
REQ-021 in_ready SHALL rise in the same cycle as out_valid; a sample accepted in that cycle starts the next run with no gap.
REQ-022 in_valid during RUN SHALL be ignored; samples are not queued and the delay line is unchanged.
REQ-023 out SHALL hold its value between out_valid pulses.
REQ-024 coef_we in IDLE SHALL write c[coef_addr] <= coef_data at the edge.
REQ-025 coef_we in RUN SHALL be ignored.
REQ-026 coef_addr >= TAPS SHALL be ignored.
REQ-027 If a coefficient write and a sample accept occur on the same edge, the new coefficient SHALL apply to that run.
REQ-028 Width: each tap contributes at most 2^N-1 ones, so acc and out (OW bits) SHALL never overflow.
REQ-029 Arithmetic SHALL be unsigned only, with no saturation.

Reset
REQ-030 While reset is high at an edge: state <= IDLE, x[*] <= 0, c[*] <= 0, cnt <= 0, acc <= 0, out <= 0, out_valid <= 0.
REQ-031 Reset SHALL take priority over accept, coefficient writes and RUN updates.
REQ-032 Reset mid-RUN SHALL abort the run with no out_valid pulse; in_ready is high in the first cycle after reset deasserts.

Verification
REQ-033 Reset: assert reset 2 cycles -> out=0, out_valid=0, in_ready=1; the first sample with all c=0 yields out=0.
REQ-034 N=4, TAPS=3, c[0]=8: accept in_data=8 -> exactly 16 edges later out=4, out_valid for 1 cycle, in_ready=1.
REQ-035 N=4, TAPS=3, all c=15: feed 15, 15, 15 back-to-back on each out_valid cycle -> out=15, 30, 45, and the runs are 16 cycles apart.
REQ-036 N=4, TAPS=3, c=[0,0,15]: feed 15, 0, 0 -> out=0, 0, 15, which checks delay-line order.
REQ-037 N=4: coef_we during RUN and in_valid during RUN -> current and next results are unaffected and no extra accept occurs; reset at cnt=7 -> no out_valid, and the next run with all c=0 gives 0.
REQ-038 Defaults N=12, TAPS=19: c[0]=2048, x=2048 -> out=1024 after 4096 edges; all c=4095 and 19 samples of 4095 -> final out=77805.

Source files
------------

// File: rtl/sc_fir_engine.sv
// sc_fir_engine -- stochastic-computing FIR filter.
//
// Each accepted sample shifts into a TAPS-deep delay line, then a run of
// 2^N cycles evaluates every tap as a unipolar stochastic product: the
// sample stream comes from a counter comparator (cnt < x[k]) and the
// coefficient stream from a van-der-Corput comparator (bitrev(cnt) < c[k]).
// The ones of all taps are summed over the run into a binary result.
//
// Ports:
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-high
//   in_data    in   N-bit unsigned sample (value x/2^N)
//   in_valid   in   sample offered
//   in_ready   out  high only while idle; a sample is accepted on valid&&ready
//   coef_we    in   coefficient write strobe (honoured only while idle)
//   coef_addr  in   AW-bit tap index; indices >= TAPS are ignored
//   coef_data  in   N-bit unsigned coefficient
//   out        out  OW-bit filter result, held between pulses
//   out_valid  out  one-cycle pulse when out is updated
module sc_fir_engine #(
    parameter  int N    = 12,
    parameter  int TAPS = 19,
    localparam int AW   = $clog2(TAPS),
    localparam int OW   = N + 1 + AW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [N-1:0]  coef_data,
    output logic [OW-1:0] out,
    output logic          out_valid
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [AW:0] TAPS_W = (AW + 1)'(TAPS);

    state_e        state_q, state_d;
    logic [N-1:0]  cnt_q, cnt_d;
    logic [OW-1:0] acc_q, acc_d;
    logic [OW-1:0] out_q, out_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  x_q [TAPS];
    logic [N-1:0]  x_d [TAPS];
    logic [N-1:0]  c_q [TAPS];
    logic [N-1:0]  c_d [TAPS];

    logic [TAPS-1:0] bits;
    logic [AW:0]     ones;
    logic [N-1:0]    cnt_rev;
    logic [OW-1:0]   sum;
    logic            idle;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] v);
        logic [N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            r[i] = v[N-1-i];
        end
        return r;
    endfunction

    // Per-tap stochastic product bits and their popcount for this cycle.
    always_comb begin
        cnt_rev = bitrev(cnt_q);
        bits    = '0;
        ones    = '0;
        for (int unsigned k = 0; k < TAPS; k++) begin
            bits[k] = (cnt_q < x_q[k]) && (cnt_rev < c_q[k]);
            ones    = ones + {{AW{1'b0}}, bits[k]};
        end
        sum = acc_q + OW'(ones);
    end

    assign idle = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        x_d         = x_q;
        c_d         = c_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    for (int unsigned k = TAPS - 1; k >= 1; k--) begin
                        x_d[k] = x_q[k-1];
                    end
                    x_d[0]  = in_data;
                    cnt_d   = '0;
                    acc_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + N'(1);
                if (cnt_q == '1) begin
                    out_d       = sum;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Written independently of accept so a same-edge write is already
        // in place for the run that starts on that edge.
        if (idle && coef_we && ({1'b0, coef_addr} < TAPS_W)) begin
            c_d[coef_addr] = coef_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                x_q[k] <= '0;
                c_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            c_q         <= c_d;
        end
    end

    assign in_ready  = idle;
    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule
